// File: rtl/regbank_mp.sv
// Parametrised multi-read-port register bank with hardwired zero register, write bypass,
// per-register pending bits and a sequential clear engine.
module regbank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     clr_start,
    output logic                     busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic                clr_done_r;
    logic [DATA_W-1:0]   regs_r [DEPTH];
    logic [DEPTH-1:0]    pend_r;
    logic                idle_s;
    logic                wr_acc_s;
    logic                mark_acc_s;
    logic                last_s;

    // Register 0 is hardwired to zero when ZERO_REG is enabled.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    assign idle_s     = (state_r == ST_IDLE);
    assign wr_acc_s   = wr_en & idle_s & ~is_zero_reg(wr_addr);
    assign mark_acc_s = mark_en & idle_s & ~is_zero_reg(mark_addr);
    // Pointer wraps at ADDR_W bits, so all-ones marks the final register of a sweep.
    assign last_s     = (state_r == ST_CLEAR) && (&ptr_r);

    assign wr_ready = idle_s;
    assign busy     = (state_r == ST_CLEAR);
    assign clr_done = clr_done_r;

    // Clear FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_start) state_s = ST_CLEAR;
                else           state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (last_s) state_s = ST_IDLE;
                else        state_s = ST_CLEAR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Clear FSM state, sweep pointer and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {ADDR_W{1'b0}};
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            clr_done_r <= last_s;
            if (state_r == ST_CLEAR) ptr_r <= ptr_r + ADDR_W'(1'b1);
            else                     ptr_r <= {ADDR_W{1'b0}};
        end
    end

    // Register file and pending bits; a mark issued alongside a write leaves the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs_r[i] <= {DATA_W{1'b0}};
            pend_r <= {DEPTH{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            regs_r[ptr_r] <= {DATA_W{1'b0}};
            pend_r[ptr_r] <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                regs_r[wr_addr] <= wr_data;
                pend_r[wr_addr] <= 1'b0;
            end
            if (mark_acc_s) pend_r[mark_addr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] data_s;
        logic              pend_s;

        assign ra_s = rd_addr[g*ADDR_W +: ADDR_W];

        // Per-port read mux: zero register overrides bypass, bypass overrides storage.
        always_comb begin
            data_s = regs_r[ra_s];
            pend_s = pend_r[ra_s];
            if (is_zero_reg(ra_s)) begin
                data_s = {DATA_W{1'b0}};
                pend_s = 1'b0;
            end else if ((BYPASS != 0) && wr_acc_s && (wr_addr == ra_s)) begin
                data_s = wr_data;
                pend_s = 1'b0;
            end else begin
                data_s = regs_r[ra_s];
                pend_s = pend_r[ra_s];
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = data_s;
        assign rd_pend[g]                  = pend_s;
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed self-checking bench for regbank_mp (default parameters plus a BYPASS=0 copy).
module tb_regbank_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic        clr_start;
    logic        busy;
    logic        clr_done;

    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_pend;
    logic        nb_wr_ready;
    logic        nb_busy;
    logic        nb_clr_done;

    int n_chk  = 0;
    int n_fail = 0;

    regbank_mp u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mark_en(mark_en), .mark_addr(mark_addr), .clr_start(clr_start),
        .busy(busy), .clr_done(clr_done)
    );

    regbank_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_pend(nb_rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(nb_wr_ready),
        .mark_en(mark_en), .mark_addr(mark_addr), .clr_start(clr_start),
        .busy(nb_busy), .clr_done(nb_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setrd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle_in();
        wr_en = 1'b0; mark_en = 1'b0; clr_start = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_idx;
        logic [31:0] acc_data;
        logic [1:0]  acc_pend;

        rst = 1'b1; rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        mark_en = 1'b0; mark_addr = 5'd0; clr_start = 1'b0;
        setrd(5'd5, 5'd7);

        // Asynchronous reset with no clock edge
        #2 rst = 1'b0;
        #1;
        check("rst_rd0", rd_data[31:0], 32'd0);
        check("rst_rd1", rd_data[63:32], 32'd0);
        check("rst_pend", {30'd0, rd_pend}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_clr_done", {31'd0, clr_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Write r5 with same-cycle bypass read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; setrd(5'd5, 5'd5);
        #1;
        check("bypass_rd0", rd_data[31:0], 32'hDEADBEEF);
        check("nobypass_old", nb_rd_data[31:0], 32'd0);
        cyc();
        idle_in();
        #1;
        check("wr_rd0", rd_data[31:0], 32'hDEADBEEF);
        check("wr_rd1", rd_data[63:32], 32'hDEADBEEF);
        check("nobypass_new", nb_rd_data[31:0], 32'hDEADBEEF);

        // Zero register ignores writes and marks
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        mark_en = 1'b1; mark_addr = 5'd0; setrd(5'd0, 5'd0);
        #1;
        check("r0_bypass_rd0", rd_data[31:0], 32'd0);
        check("r0_bypass_rd1", rd_data[63:32], 32'd0);
        cyc();
        idle_in();
        #1;
        check("r0_rd0", rd_data[31:0], 32'd0);
        check("r0_rd1", rd_data[63:32], 32'd0);
        check("r0_pend", {30'd0, rd_pend}, 32'd0);

        // Scoreboard: mark, write clears, mark+write leaves pending
        mark_en = 1'b1; mark_addr = 5'd7; setrd(5'd7, 5'd5);
        #1;
        check("mark_pend_before", {31'd0, rd_pend[0]}, 32'd0);
        cyc();
        idle_in();
        #1;
        check("mark_pend_after", {31'd0, rd_pend[0]}, 32'd1);
        check("mark_other_port", {31'd0, rd_pend[1]}, 32'd0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #1;
        check("wr_bypass_pend", {31'd0, rd_pend[0]}, 32'd0);
        check("wr_bypass_data", rd_data[31:0], 32'h55);
        cyc();
        idle_in();
        #1;
        check("wr_clears_pend", {31'd0, rd_pend[0]}, 32'd0);
        check("wr_r7_data", rd_data[31:0], 32'h55);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; mark_en = 1'b1; mark_addr = 5'd7;
        cyc();
        idle_in();
        #1;
        check("markwr_pend", {31'd0, rd_pend[0]}, 32'd1);
        check("markwr_data", rd_data[31:0], 32'h77);
        check("p1_r5", rd_data[63:32], 32'hDEADBEEF);

        // Fill r1..r31 with their index, mark r3 on the last write
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            mark_en = (i == 31); mark_addr = 5'd3;
            cyc();
        end
        idle_in();
        setrd(5'd3, 5'd31);
        #1;
        check("fill_r3_pend", {31'd0, rd_pend[0]}, 32'd1);
        check("fill_r31", rd_data[63:32], 32'd31);

        // Sequential clear with writes and marks held throughout
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd1);
        check("clr_wr_ready", {31'd0, wr_ready}, 32'd0);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hBAD; mark_en = 1'b1; mark_addr = 5'd2;
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) begin
                setrd(5'd20, 5'd5);
                #1;
                check("mid_clr_r20", rd_data[31:0], 32'd20);
                check("mid_clr_r5", rd_data[63:32], 32'd0);
            end
            if (busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_idx = k;
            end
            if (!busy) idle_in();
            cyc();
        end
        idle_in();
        check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clr_done_count", 32'(done_cnt), 32'd1);
        check("clr_done_index", 32'(done_idx), 32'd32);
        acc_data = 32'd0; acc_pend = 2'd0;
        for (int i = 0; i < 32; i++) begin
            setrd(5'(i), 5'(31 - i));
            #1;
            acc_data = acc_data | rd_data[31:0] | rd_data[63:32];
            acc_pend = acc_pend | rd_pend;
        end
        check("clr_all_data", acc_data, 32'd0);
        check("clr_all_pend", {30'd0, acc_pend}, 32'd0);

        // Reset during a clear sweep
        cyc();
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h25; mark_en = 1'b1; mark_addr = 5'd25;
        setrd(5'd25, 5'd25);
        cyc();
        idle_in();
        #1;
        check("pre_rst_r25", rd_data[31:0], 32'h25);
        check("pre_rst_pend", {31'd0, rd_pend[0]}, 32'd1);
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        repeat (10) cyc();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstclr_busy", {31'd0, busy}, 32'd0);
        check("rstclr_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rstclr_r25", rd_data[31:0], 32'd0);
        check("rstclr_pend", {31'd0, rd_pend[0]}, 32'd0);
        #1 rst = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (clr_done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("rstclr_no_done", 32'(done_cnt), 32'd0);
        check("rstclr_no_busy", 32'(busy_cnt), 32'd0);
        check("nb_idle", {30'd0, nb_busy, nb_clr_done}, 32'd0);
        check("nb_ready", {31'd0, nb_wr_ready}, 32'd1);
        check("nb_pend", {30'd0, nb_rd_pend}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
